// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_pkg
//  Purpose  : Shared types and constants for the direct-mapped write-back
//             data cache (geometry, address field positions, FSM states).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  localparam int INDEX_BITS = 5;
  localparam int TAG_BITS   = 23;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 128;
  localparam int NUM_LINES  = 1 << INDEX_BITS;

  // Address field positions: tag = [31:9], index = [8:4], word = [3:2]
  localparam int WORD_LSB  = 2;
  localparam int INDEX_LSB = 4;
  localparam int TAG_LSB   = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_tag_data_array.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_tag_data_array
//  Purpose  : Tag, valid, dirty and data storage for the data cache.
//             Combinational read of one line; synchronous writes.
//  Ports    : clk        - clock, rising edge
//             clr_valid  - synchronous clear of all valid and dirty bits
//             index      - line selected for both read and write
//             valid/dirty/tag/line - read port for the selected line
//             line_we    - refill: write line_data + tag_data, set valid,
//                          clear dirty
//             word_we    - per-word store enables (one-hot from the ctrl)
//             word_data  - store data for enabled words
//             dirty_set  - mark selected line dirty
//             dirty_clr  - mark selected line clean
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_tag_data_array
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr_valid,
  input  logic [INDEX_BITS-1:0] index,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAG_BITS-1:0]   tag,
  output logic [LINE_BITS-1:0]  line,
  input  logic                  line_we,
  input  logic [LINE_BITS-1:0]  line_data,
  input  logic [TAG_BITS-1:0]   tag_data,
  input  logic [LINE_WORDS-1:0] word_we,
  input  logic [31:0]           word_data,
  input  logic                  dirty_set,
  input  logic                  dirty_clr
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
  logic [LINE_BITS-1:0] r_data [NUM_LINES];

  assign valid = r_valid[index];
  assign dirty = r_dirty[index];
  assign tag   = r_tag[index];
  assign line  = r_data[index];

  // Status bits are the only state that needs clearing.
  always_ff @(posedge clk) begin
    if (clr_valid) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (line_we) begin
        r_valid[index] <= 1'b1;
        r_dirty[index] <= 1'b0;
      end
      if (dirty_set) r_dirty[index] <= 1'b1;
      if (dirty_clr) r_dirty[index] <= 1'b0;
    end
  end

  // Refill replaces the whole line; otherwise only enabled words change,
  // so a store never disturbs its neighbours.
  always_ff @(posedge clk) begin
    if (line_we) begin
      r_tag[index]  <= tag_data;
      r_data[index] <= line_data;
    end else begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        if (word_we[w]) r_data[index][w*32 +: 32] <= word_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Direct-mapped, write-back, write-allocate data cache controller
//             for the MEM stage. Hits complete with no stall; misses stall
//             the pipeline while a dirty victim is written back and the line
//             is refilled from 128-bit main memory (req/ack handshake).
//  Ports    : clk_i, rst_i (sync, active-low)
//             cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i - CPU access (held
//                 stable by the pipeline while stall_o is high)
//             cpu_rdata_o - load data, 0 unless a read hit
//             stall_o     - pipeline freeze
//             mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o - memory request
//             mem_ack_i/mem_rdata_i - one-cycle completion + refill data
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
);

  state_t r_state;
  state_t w_next;

  logic [TAG_BITS-1:0]   w_cpu_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_word;
  logic                  w_valid;
  logic                  w_dirty;
  logic [TAG_BITS-1:0]   w_tag;
  logic [LINE_BITS-1:0]  w_line;
  logic                  w_hit;
  logic                  w_line_we;
  logic [LINE_WORDS-1:0] w_word_we;
  logic                  w_dirty_set;
  logic                  w_dirty_clr;
  logic                  w_unused_addr;

  assign w_cpu_tag     = cpu_addr_i[31:TAG_LSB];
  assign w_index       = cpu_addr_i[TAG_LSB-1:INDEX_LSB];
  assign w_word        = cpu_addr_i[INDEX_LSB-1:WORD_LSB];
  assign w_unused_addr = ^cpu_addr_i[WORD_LSB-1:0];

  assign w_hit = cpu_req_i & w_valid & (w_tag == w_cpu_tag);

  dcache_tag_data_array u_array (
    .clk       (clk_i),
    .clr_valid (~rst_i),
    .index     (w_index),
    .valid     (w_valid),
    .dirty     (w_dirty),
    .tag       (w_tag),
    .line      (w_line),
    .line_we   (w_line_we),
    .line_data (mem_rdata_i),
    .tag_data  (w_cpu_tag),
    .word_we   (w_word_we),
    .word_data (cpu_wdata_i),
    .dirty_set (w_dirty_set),
    .dirty_clr (w_dirty_clr)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    cpu_rdata_o = 32'h0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = '0;
    w_line_we   = 1'b0;
    w_word_we   = '0;
    w_dirty_set = 1'b0;
    w_dirty_clr = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_hit) begin
          if (cpu_we_i) begin
            // Gated by reset so a store in the reset cycle cannot leave
            // a dirty line behind.
            w_word_we   = rst_i ? (LINE_WORDS'(1) << w_word) : '0;
            w_dirty_set = rst_i;
          end else begin
            cpu_rdata_o = w_line[w_word*32 +: 32];
          end
        end else if (cpu_req_i) begin
          stall_o = 1'b1;
          w_next  = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        // Index is unchanged by the held request, so the array still
        // presents the victim line and its tag.
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {w_tag, w_index, 4'b0000};
        mem_wdata_o = w_line;
        if (mem_ack_i) begin
          w_dirty_clr = 1'b1;
          w_next      = ALLOCATE;
        end
      end

      ALLOCATE: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {w_cpu_tag, w_index, 4'b0000};
        if (mem_ack_i) begin
          w_line_we = rst_i;
          w_next    = IDLE;
        end
      end

      default: w_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Purpose  : Directed self-checking bench for dcache_ctrl with a simple
//             latency-programmable main-memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ack_i;
  logic [127:0] mem_rdata_i;

  logic model_ack = 1'b0;
  logic spur_ack  = 1'b0;
  assign mem_ack_i = model_ack | spur_ack;

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- main-memory model ----------------
  int           lat = 3;
  int           req_cnt = 0;
  logic         wb_seen = 1'b0;
  logic [31:0]  wb_addr = 32'h0;
  logic [127:0] wb_data = '0;
  logic [31:0]  alloc_addr = 32'h0;
  logic [127:0] backing [logic [31:0]];

  function automatic logic [127:0] pattern(input logic [31:0] a);
    return {a + 32'hA000_000C, a + 32'hA000_0008, a + 32'hA000_0004, a + 32'hA000_0000};
  endfunction

  // Ack is raised in the lat-th cycle of a request and held for one cycle.
  always @(posedge clk_i) begin
    #1;
    if (mem_req_o) begin
      if (mem_we_o) begin
        wb_seen = 1'b1;
        wb_addr = mem_addr_o;
        wb_data = mem_wdata_o;
      end else begin
        alloc_addr = mem_addr_o;
      end
      req_cnt++;
      if (req_cnt >= lat) begin
        req_cnt   = 0;
        model_ack = 1'b1;
        if (mem_we_o) backing[mem_addr_o] = mem_wdata_o;
        else mem_rdata_i = backing.exists(mem_addr_o) ? backing[mem_addr_o] : pattern(mem_addr_o);
      end else begin
        model_ack = 1'b0;
      end
    end else begin
      req_cnt   = 0;
      model_ack = 1'b0;
    end
  end

  // One CPU access held until the stall drops; store commits at the edge
  // that ends the hit cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rd);
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    #1;
    stalls = 0;
    while (stall_o && stalls < 50) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    rd = cpu_rdata_o;
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    rst_i       = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_wdata_i = 32'h0;
    mem_rdata_i = '0;
    backing[32'h40] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rst_stall", stall_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_rdata", cpu_rdata_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);

    // 1. cold load
    access(1'b0, 32'h40, 32'h0, st, rd);
    check("t1_stall", st, 4);
    check("t1_alloc_addr", alloc_addr, 32'h40);
    check("t1_wb_seen", wb_seen, 0);
    check("t1_rdata", rd, 32'h0000_1111);

    // 2. write hit then reads
    access(1'b1, 32'h44, 32'hDEAD_BEEF, st, rd);
    check("t2_store_stall", st, 0);
    access(1'b0, 32'h44, 32'h0, st, rd);
    check("t2_ld44_stall", st, 0);
    check("t2_ld44", rd, 32'hDEAD_BEEF);
    access(1'b0, 32'h40, 32'h0, st, rd);
    check("t2_ld40", rd, 32'h0000_1111);
    access(1'b0, 32'h48, 32'h0, st, rd);
    check("t2_ld48", rd, 32'h0000_3333);

    // 3. dirty eviction
    access(1'b0, 32'h240, 32'h0, st, rd);
    check("t3_stall", st, 7);
    check("t3_wb_seen", wb_seen, 1);
    check("t3_wb_addr", wb_addr, 32'h40);
    check("t3_wb_data", wb_data, {32'h4444, 32'h3333, 32'hDEAD_BEEF, 32'h1111});
    check("t3_alloc_addr", alloc_addr, 32'h240);
    check("t3_rdata", rd, 32'hA000_0240);

    // 4. clean eviction, refill returns the written-back line
    wb_seen = 1'b0;
    access(1'b0, 32'h44, 32'h0, st, rd);
    check("t4_stall", st, 4);
    check("t4_wb_seen", wb_seen, 0);
    check("t4_alloc_addr", alloc_addr, 32'h40);
    check("t4_rdata", rd, 32'hDEAD_BEEF);
    access(1'b0, 32'h4C, 32'h0, st, rd);
    check("t4_ld4c_stall", st, 0);
    check("t4_ld4c", rd, 32'h0000_4444);

    // 5. spurious ack while idle
    @(negedge clk_i);
    spur_ack = 1'b1;
    #1;
    check("t5_stall", stall_o, 0);
    check("t5_mem_req", mem_req_o, 0);
    check("t5_rdata", cpu_rdata_o, 0);
    @(posedge clk_i);
    #1;
    spur_ack = 1'b0;
    check("t5_post_mem_req", mem_req_o, 0);
    check("t5_post_stall", stall_o, 0);
    access(1'b0, 32'h44, 32'h0, st, rd);
    check("t5_hit_stall", st, 0);
    check("t5_hit_rdata", rd, 32'hDEAD_BEEF);

    // 6. reset in the middle of a refill
    lat = 10;
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h140;
    #1;
    check("t6_miss_stall", stall_o, 1);
    repeat (2) @(negedge clk_i);
    check("t6_alloc_req", mem_req_o, 1);
    check("t6_alloc_addr", mem_addr_o, 32'h140);
    rst_i     = 1'b0;
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("t6_rst_mem_req", mem_req_o, 0);
    check("t6_rst_stall", stall_o, 0);
    rst_i = 1'b1;
    lat   = 3;
    access(1'b0, 32'h40, 32'h0, st, rd);
    check("t6_reload40_stall", st, 4);
    check("t6_reload40", rd, 32'h0000_1111);
    access(1'b0, 32'h140, 32'h0, st, rd);
    check("t6_reload140_stall", st, 4);
    check("t6_reload140", rd, 32'hA000_0140);

    repeat (2) @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
